// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - boot-time byte-stream loader for the instruction memory
//
// Takes a length-prefixed program image over a valid/ready byte link. It assembles
// little-endian 32-bit words and issues one write per word to the instruction memory.
// The core is held in reset until the whole image has been written.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte after the payload.
//
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   in_valid, in_data, in_ready host byte stream (transfer on in_valid & in_ready)
//   restart                     pulse: drop the current image, wait for a new header
//   mem_we, mem_addr, mem_wdata instruction memory write port (one pulse per word)
//   core_hold                   keeps the core's PC and fetch in reset while high
//   load_done, load_error       final status of the image
//   words_loaded                mem_we pulses since the last reset or restart
`timescale 1ns/1ps

module imem_program_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_FINISH,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_idx;   // wider than ADDR_W so N == DEPTH never wraps the compare
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;      // bytes 0..2 of the word in flight; byte 3 comes straight from in_data
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        accept;
    logic [15:0] len_full;
    logic        last_word;

    assign len_full  = {in_data, len_lo};
    assign last_word = (word_idx + 16'd1) == len;
    assign accept    = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        if (reset && !restart) begin
            case (state)
                S_LEN_LO, S_LEN_HI, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM:                     in_ready = 1'b1;
`endif
                default:                    in_ready = 1'b0;
            endcase
        end
    end

    // Status comes straight from the state: only a completed image releases the core.
    assign core_hold  = (state != S_DONE);
    assign load_done  = (state == S_DONE);
    assign load_error = (state == S_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LEN_LO;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = S_LEN_LO;
        end else begin
            case (state)
                S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
                S_LEN_HI: begin
                    if (accept) begin
                        if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_nxt = S_CSUM;
`else
                            state_nxt = S_DONE;
`endif
                        end else if (len_full > DEPTH_W) begin
                            state_nxt = S_ERROR;
                        end else begin
                            state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept && byte_cnt == 2'd3 && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_FINISH;
`endif
                    end
                end
                // The last word's write pulse is out during this cycle, so the core is
                // released only after it has landed.
                S_FINISH: state_nxt = S_DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
                end
`endif
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            words_loaded <= 16'd0;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            word_idx     <= 16'd0;
            byte_cnt     <= 2'd0;
            asm_q        <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (restart) begin
                // A partial word is simply dropped: byte_cnt restarts and no pulse is issued.
                words_loaded <= 16'd0;
                word_idx     <= 16'd0;
                byte_cnt     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum         <= 8'd0;
`endif
            end else if (accept) begin
                if (state == S_LEN_LO) begin
                    len_lo <= in_data;
                end
                if (state == S_LEN_HI) begin
                    len      <= len_full;
                    word_idx <= 16'd0;
                    byte_cnt <= 2'd0;
                end
                if (state == S_DATA) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    asm_q    <= {in_data, asm_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum     <= csum ^ in_data;
`endif
                    if (byte_cnt == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx[ADDR_W-1:0];
                        mem_wdata <= {in_data, asm_q};
                        word_idx  <= word_idx + 16'd1;
                        if (words_loaded != 16'hFFFF) begin
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                end
            end
        end
    end

endmodule
